// File: rtl/fp_sum_seq.sv
// Streaming packet summer that drives an external combinational/pipelined fp_adder.
// Optional sticky status flags (out_flags) are enabled by defining FP_SUM_SEQ_FLAGS_EN.
module fp_sum_seq #(
  parameter int CNT_W   = 16,
  parameter int ADD_LAT = 0   // legal 0..7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             in_last,
  output logic [31:0]      adder_a,
  output logic [31:0]      adder_b,
  input  logic [31:0]      adder_s,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [CNT_W-1:0] out_count
`ifdef FP_SUM_SEQ_FLAGS_EN
  ,
  output logic [2:0]       out_flags
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_ADD, S_OUT} state_e;

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [2:0]       WAIT_INIT = 3'(ADD_LAT);

  state_e           state_q, state_d;
  logic [31:0]      acc_q, acc_d;
  logic [31:0]      op_q, op_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [2:0]       wcnt_q, wcnt_d;
  logic             accept;
  logic             sum_done;

  assign in_ready = rst_n && (state_q == S_IDLE || state_q == S_ACC);
  assign accept   = in_valid && in_ready;
  assign sum_done = (state_q == S_ADD) && (wcnt_q == 3'd0);

  // NOTE: every _d gets its current value first so no path through the case infers a latch.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    op_d    = op_q;
    last_d  = last_q;
    count_d = count_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      S_IDLE: begin
        // First element bypasses the adder so -0 and denormals survive bit-exact.
        if (accept) begin
          acc_d   = in_data;
          count_d = CNT_W'(1);
          state_d = in_last ? S_OUT : S_ACC;
        end
      end
      S_ACC: begin
        if (accept) begin
          op_d    = in_data;
          last_d  = in_last;
          wcnt_d  = WAIT_INIT;
          state_d = S_ADD;
        end
      end
      S_ADD: begin
        if (wcnt_q != 3'd0) begin
          wcnt_d = wcnt_q - 3'd1;
        end else begin
          acc_d   = adder_s;
          count_d = (count_q == CNT_MAX) ? count_q : count_q + CNT_W'(1);
          state_d = last_q ? S_OUT : S_ACC;
        end
      end
      S_OUT: begin
        if (out_ready) begin
          count_d = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      op_q    <= '0;
      last_q  <= 1'b0;
      count_q <= '0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      op_q    <= op_d;
      last_q  <= last_d;
      count_q <= count_d;
      wcnt_q  <= wcnt_d;
    end
  end

  assign adder_a   = acc_q;
  assign adder_b   = op_q;
  assign out_valid = (state_q == S_OUT);
  assign out_data  = acc_q;
  assign out_count = count_q;

`ifdef FP_SUM_SEQ_FLAGS_EN
  logic [2:0] flags_q, flags_d;

  // Sticky per packet; wiped when the total is handed off and IDLE is re-entered.
  always_comb begin
    flags_d = flags_q;
    if (accept && in_data[30:23] == 8'hFF) flags_d[0] = 1'b1;
    if (sum_done && adder_s[30:23] == 8'hFF) flags_d[1] = 1'b1;
    if (sum_done && count_q == CNT_MAX) flags_d[2] = 1'b1;
    if (state_q == S_OUT && out_ready) flags_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) flags_q <= '0;
    else        flags_q <= flags_d;
  end

  assign out_flags = flags_q;
`endif

endmodule

// File: doc/fp_sum_seq.md
Name: fp_sum_seq

Overview:
- Streaming sequencer that sits directly upstream and downstream of the combinational single-precision adder (fp_adder).
- Accepts a packet of IEEE-754 single-precision operands over a valid/ready stream and drives the adder's a/b inputs. Accumulates the adder's sum s into a running register.
- Emits one total per packet on a valid/ready output. The adder stays a separate instance wired at the next level up.

Parameters:
- CNT_W, 16, width of the element counter reported with each total.
- ADD_LAT, 0, extra clock cycles to wait after presenting operands before sampling adder_s (0 = purely combinational adder; legal 0..7).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- in_valid  input  1  operand valid.
- in_ready  output  1  block can accept an operand this cycle.
- in_data  input  32  operand, IEEE-754 single.
- in_last  input  1  operand is final element of packet.
- adder_a  output  32  to fp_adder a (running sum).
- adder_b  output  32  to fp_adder b (held operand).
- adder_s  input  32  from fp_adder s.
- out_valid  output  1  total valid.
- out_ready  input  1  consumer accepts total.
- out_data  output  32  packet total.
- out_count  output  CNT_W  number of elements in packet.

Behaviour:
- Reset (rst_n low at a rising edge):
  - State goes to IDLE; acc, op_reg, count and wait counter are cleared to 0.
  - out_valid=0, out_data=0, out_count=0, adder_a=0, adder_b=0.
  - in_ready is forced 0 while rst_n is low.
- Accept condition: in_valid && in_ready at a rising edge. in_data and in_last are ignored otherwise.
- in_ready=1 only in IDLE and ACC.
- States:
  - IDLE (first element of a new packet): on accept, acc<=in_data directly, bypassing the adder so a -0 or denormal first operand is preserved bit-exact; count<=1. Next state is OUT if in_last, else ACC.
  - ACC: on accept, op_reg<=in_data, last_reg<=in_last, wcnt<=ADD_LAT. Next state is ADD. Without an accept, stay in ACC indefinitely.
  - ADD: in_ready=0; adder_a=acc, adder_b=op_reg, both stable for the whole state.
    - If wcnt!=0: wcnt decrements.
    - If wcnt==0: acc<=adder_s, count<=count+1 (saturates at all-ones). Next state is OUT if last_reg, else ACC.
  - OUT: out_valid=1, out_data=acc, out_count=count, all held stable until out_ready.
    - On out_valid && out_ready: return to IDLE; out_valid drops next cycle; count clears.
- Outside ADD, adder_a=acc and adder_b=op_reg (last values); downstream must not rely on them.
- Timing:
  - Throughput: one operand per 2+ADD_LAT cycles after the first.
  - Latency from accepting the last element to out_valid: 1 cycle for a 1-element packet; 2+ADD_LAT cycles otherwise.
- Arithmetic: no rounding or normalisation inside this block; all arithmetic is the adder's. Totals are bit-exact copies of adder_s.
- Simultaneous events:
  - in_valid during ADD or OUT is not accepted; upstream must hold.
  - out_ready while not in OUT is ignored.
  - A single-element packet in IDLE with in_last=1 goes straight to OUT.
- Reset mid-packet discards the partial sum and count with no output; the next accepted element starts a new packet.
- Zero-length packets do not exist; the first accepted element always opens a packet.

Optional Feature:
- Macro FP_SUM_SEQ_FLAGS_EN.
- When defined, add output out_flags [2:0], valid with out_valid and held with out_data. Flags are sticky per packet and cleared on reset and on entering IDLE.
  - bit0 = an operand with exponent 8'hFF (Inf/NaN) was accepted.
  - bit1 = a sampled adder_s had exponent 8'hFF (overflow or wrap).
  - bit2 = count saturated.
- When undefined, the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Single element 32'h40400000 (3.0) with in_last=1 in IDLE -> next cycle out_valid=1, out_data=32'h40400000, out_count=1; -0 (32'h80000000) alone -> out_data=32'h80000000.
- Packet 1.0 (32'h3F800000), 2.0 (32'h40000000, last), ADD_LAT=0, real fp_adder wired -> out_data=32'h40400000, out_count=2, out_valid exactly 2 cycles after the last accept.
- Packet 1.5 (32'h3FC00000), -1.5 (32'hBFC00000, last) -> out_data=32'h00000000; then 4x 1.0 -> 32'h40800000, count=4.
- out_ready held low 5 cycles in OUT -> out_data/out_count stable, in_ready=0, in_valid with 32'h41200000 not accepted until after the handshake.
- ADD_LAT=2, bench adder model with 2-cycle registered output -> adder_a/adder_b stable 3 cycles per element, sum 1.0+2.0+4.0 = 32'h40E00000.
- rst_n low for one cycle after 2 of 3 elements -> no out_valid; the next packet 5.0 (32'h40A00000, last) -> out_data=32'h40A00000, count=1. With FP_SUM_SEQ_FLAGS_EN: operand 32'h7F800000 -> out_flags bit0=1.
